// File: rtl/dbus_resp.sv
// rtl/dbus_resp.sv - fixed-latency data-bus responder backed by a word-addressed array
// Accepts one load/store at a time, stalls the master, and completes with a one-cycle strobe.
module dbus_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbus_en,
    input  logic [3:0]  dbus_we,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_data,
    output logic        dbus_stall,
    output logic        dbus_rvalid,
    output logic [31:0] dbus_rdata,
    output logic        dbus_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        stall_c;
    logic        enter_done;

    logic [31:0] mem [DEPTH_WORDS];

    // Request seen by the decoder: live inputs when completing straight out of IDLE
    // (LATENCY==1), otherwise the copy captured at acceptance.
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [31:0] rel_addr;
    logic [31:0] word_off;
    logic [AW-1:0] idx;
    logic [1:0]  ofs;
    logic        out_of_range;
    logic        misaligned;
    logic        req_err;
    logic [3:0]  lane_mask;
    logic [31:0] wdata;
    logic        do_write;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        stall_c    = 1'b0;
        enter_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (dbus_en) begin
                    stall_c = 1'b1;
                    we_d    = dbus_we;
                    addr_d  = dbus_addr;
                    data_d  = dbus_data;
                    if (LATENCY > 1) begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dbus_stall = stall_c & ~rst;

    always_comb begin
        req_we       = (state_q == IDLE) ? dbus_we   : we_q;
        req_addr     = (state_q == IDLE) ? dbus_addr : addr_q;
        req_data     = (state_q == IDLE) ? dbus_data : data_q;
        rel_addr     = req_addr - BASE_ADDR;
        word_off     = rel_addr >> 2;
        idx          = word_off[AW-1:0];
        ofs          = req_addr[1:0];
        out_of_range = (word_off >= 32'(DEPTH_WORDS));
        case (req_we)
            4'b0000: misaligned = 1'b0;
            4'b0001: misaligned = 1'b0;
            4'b0011: misaligned = ofs[0];
            4'b1111: misaligned = (ofs != 2'b00);
            default: misaligned = 1'b1;
        endcase
        req_err   = misaligned | out_of_range;
        lane_mask = req_we << ofs;
        wdata     = req_data << {ofs, 3'b000};
        do_write  = enter_done & ~rst & ~req_err & (req_we != 4'b0000);
    end

    // Array contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 4'd0;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rvalid_q <= enter_done;
            if (enter_done) begin
                rdata_q <= out_of_range ? 32'd0 : mem[idx];
                err_q   <= req_err;
            end
        end
    end

    assign dbus_rvalid = rvalid_q;
    assign dbus_rdata  = rdata_q;
    assign dbus_err    = err_q;

endmodule

// File: tb/tb_dbus_resp.sv
// tb/tb_dbus_resp.sv - scoreboard bench for dbus_resp at LATENCY 2 and LATENCY 1
module tb_dbus_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, stall_a, rvalid_a, err_a;
    logic [3:0]  we_a;
    logic [31:0] addr_a, data_a, rdata_a;
    logic        rst_b, en_b, stall_b, rvalid_b, err_b;
    logic [3:0]  we_b;
    logic [31:0] addr_b, data_b, rdata_b;

    dbus_resp #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .rst(rst_a), .dbus_en(en_a), .dbus_we(we_a), .dbus_addr(addr_a),
        .dbus_data(data_a), .dbus_stall(stall_a), .dbus_rvalid(rvalid_a),
        .dbus_rdata(rdata_a), .dbus_err(err_a)
    );

    dbus_resp #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(32'h0000_1000)) dut_b (
        .clk(clk), .rst(rst_b), .dbus_en(en_b), .dbus_we(we_b), .dbus_addr(addr_b),
        .dbus_data(data_b), .dbus_stall(stall_b), .dbus_rvalid(rvalid_b),
        .dbus_rdata(rdata_b), .dbus_err(err_b)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks = 0;
    int   failures = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rvalid_a === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                ea = qa.pop_front();
                check("a_err", {31'd0, err_a}, {31'd0, ea.err});
                if (ea.chk) check("a_rdata", rdata_a, ea.rdata);
            end
        end
        if (rvalid_b === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                eb = qb.pop_front();
                check("b_err", {31'd0, err_b}, {31'd0, eb.err});
                if (eb.chk) check("b_rdata", rdata_b, eb.rdata);
            end
        end
    end

    task automatic drive(input bit b, input logic en, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] data);
        if (b) begin
            en_b = en; we_b = we; addr_b = addr; data_b = data;
        end else begin
            en_a = en; we_a = we; addr_a = addr; data_a = data;
        end
    endtask

    task automatic issue(input bit b, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_rd,
                         input logic exp_err, input logic chk, input string name);
        exp_t e;
        int   stalls;
        int   cycles;
        bit   seen;
        int   lat;
        lat = b ? 1 : 2;
        e.rdata = exp_rd; e.err = exp_err; e.chk = chk;
        if (b) qb.push_back(e); else qa.push_back(e);
        @(negedge clk);
        drive(b, 1'b1, we, addr, data);
        #1;
        stalls = (b ? stall_b : stall_a) ? 1 : 0;
        cycles = 0;
        seen   = 1'b0;
        @(posedge clk);
        #1;
        // Scrambled inputs after acceptance must not affect the pending request.
        drive(b, 1'b0, 4'hF, ~addr, 32'hA5A5_A5A5);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if ((b ? rvalid_b : rvalid_a) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (b ? stall_b : stall_a) stalls++;
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
        check({name, "_latency"}, cycles, lat);
        check({name, "_stall_cycles"}, stalls, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        drive(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 4'h0, 32'h1000, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall_a", {31'd0, stall_a}, 32'd0);
        check("rst_rvalid_a", {31'd0, rvalid_a}, 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_err_a", {31'd0, err_a}, 32'd0);
        check("rst_stall_b", {31'd0, stall_b}, 32'd0);
        check("rst_rvalid_b", {31'd0, rvalid_b}, 32'd0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        issue(0, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "sw10");
        issue(0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, "lw10");
        issue(0, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0, 1'b0, "sw20");
        issue(0, 4'h1, 32'h22, 32'h000000AA, 32'h11223344, 1'b0, 1'b1, "sb22");
        issue(0, 4'h3, 32'h20, 32'h0000BEEF, 32'h11AA3344, 1'b0, 1'b1, "sh20");
        issue(0, 4'h0, 32'h20, 32'h0, 32'h11AABEEF, 1'b0, 1'b1, "lw20");
        issue(0, 4'h3, 32'h21, 32'h0000FFFF, 32'h0, 1'b1, 1'b0, "sh21_misal");
        issue(0, 4'hF, 32'h22, 32'h00000000, 32'h0, 1'b1, 1'b0, "sw22_misal");
        issue(0, 4'h5, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, "we0101");
        issue(0, 4'h0, 32'h20, 32'h0, 32'h11AABEEF, 1'b0, 1'b1, "lw20_unchanged");
        issue(0, 4'h3, 32'h22, 32'h00007777, 32'h11AABEEF, 1'b0, 1'b1, "sh22");
        issue(0, 4'h0, 32'h23, 32'h0, 32'h7777BEEF, 1'b0, 1'b1, "lw23_aligned");
        issue(0, 4'h1, 32'h23, 32'h123456C3, 32'h7777BEEF, 1'b0, 1'b1, "sb23");
        issue(0, 4'h0, 32'h20, 32'h0, 32'hC377BEEF, 1'b0, 1'b1, "lw20_final");
        issue(0, 4'h0, 32'h1000, 32'h0, 32'h0, 1'b1, 1'b1, "lw_oor");
        issue(0, 4'h0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1'b1, "lw_wrap");
        issue(0, 4'hF, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, "sw_last");
        issue(0, 4'h0, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, "lw_last");

        issue(0, 4'hF, 32'h30, 32'h12345678, 32'h0, 1'b0, 1'b0, "sw30");
        @(negedge clk);
        drive(0, 1'b1, 4'hF, 32'h30, 32'h00000055);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        #2;
        rst_a = 1'b1;
        #1;
        check("busy_rst_stall", {31'd0, stall_a}, 32'd0);
        check("busy_rst_rvalid", {31'd0, rvalid_a}, 32'd0);
        check("busy_rst_rdata", rdata_a, 32'd0);
        check("busy_rst_err", {31'd0, err_a}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        issue(0, 4'h0, 32'h30, 32'h0, 32'h12345678, 1'b0, 1'b1, "lw30_after_rst");

        for (int k = 0; k < 4; k++) begin
            issue(1, 4'hF, 32'h1000 + 32'(4 * k), 32'hB0B0_0000 + 32'(k), 32'h0, 1'b0, 1'b0, "b_sw");
        end
        issue(1, 4'h0, 32'h0FFC, 32'h0, 32'h0, 1'b1, 1'b1, "b_lw_wrap");
        issue(1, 4'h0, 32'h1040, 32'h0, 32'h0, 1'b1, 1'b1, "b_lw_oor");
        issue(1, 4'h0, 32'h1008, 32'h0, 32'hB0B0_0002, 1'b0, 1'b1, "b_lw8");

        for (int k = 0; k < 4; k++) begin
            qb.push_back('{rdata: 32'hB0B0_0000 + 32'(3 - k), err: 1'b0, chk: 1'b1});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, 1'b1, 4'h0, 32'h100C - 32'(4 * k), 32'h0);
            #1;
            check("b2b_idle_stall", {31'd0, stall_b}, 32'd1);
            check("b2b_idle_rvalid", {31'd0, rvalid_b}, 32'd0);
            @(negedge clk);
            #1;
            check("b2b_done_stall", {31'd0, stall_b}, 32'd0);
            check("b2b_done_rvalid", {31'd0, rvalid_b}, 32'd1);
        end
        drive(1, 1'b0, 4'h0, 32'h0, 32'h0);

        repeat (4) @(negedge clk);
        check("qa_drained", qa.size(), 32'd0);
        check("qb_drained", qb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbus_resp.md
DBUS_RESP -- requirements
Module: dbus_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the internal data array; power of two.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, byte address mapped to word 0.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 dbus_en  input  1  request present.
REQ-007 dbus_we  input  4  unshifted lane mask: 4'b0000 read, 4'b0001 byte, 4'b0011 half, 4'b1111 word.
REQ-008 dbus_addr  input  32  byte address.
REQ-009 dbus_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 dbus_stall  output  1  request accepted but not yet complete; master holds pipeline.
REQ-011 dbus_rvalid  output  1  one-cycle completion strobe.
REQ-012 dbus_rdata  output  32  aligned word read at completion; valid only with dbus_rvalid.
REQ-013 dbus_err  output  1  completion was misaligned or out of range; valid only with dbus_rvalid.

Function
REQ-014 FSM states IDLE, BUSY, DONE; IDLE after reset.
REQ-015 IDLE: dbus_en=1 -> capture we/addr/data, dbus_stall=1 combinationally that cycle, next BUSY if LATENCY>1 else DONE; dbus_en=0 -> stay IDLE, stall=0.
REQ-016 BUSY: 4-bit down-counter loaded with LATENCY-2 at acceptance; stall=1; counter==0 -> DONE, else decrement.
REQ-017 DONE: stall=0, rvalid=1, rdata/err driven from registers; next state IDLE unconditionally.
REQ-018 Acceptance-to-DONE distance is exactly LATENCY cycles; stall high for exactly LATENCY cycles per request.
REQ-019 Request inputs in BUSY/DONE ignored; captured copy used; dbus_en deassert in BUSY does not abort.
REQ-020 New request presented in the cycle after DONE is accepted in IDLE with no extra bubble.
REQ-021 Offset o=addr[1:0]; effective lane mask = we<<o; write data = data<<(8*o); only masked bytes change.
REQ-022 Misaligned: (we==4'b0011 & o[0]) or (we==4'b1111 & o!=0) -> err=1, no write.
REQ-023 Out of range: (addr-BASE_ADDR)>>2 >= DEPTH_WORDS, unsigned 32-bit subtraction with wrap -> err=1, no write, rdata=0.
REQ-024 Any other we pattern (e.g. 4'b0101) -> treated as misaligned, err=1, no write.
REQ-025 Write commits at the edge entering DONE; read samples array at the same edge into rdata register; for stores rdata returns the pre-write word.
REQ-026 Reads return the full aligned word; sign/zero extension and lane selection belong to the consumer.
REQ-027 Outputs registered except dbus_stall (function of state and dbus_en).

Reset
REQ-028 rst=1 forces state IDLE, counter 0, dbus_rvalid=0, dbus_rdata=0, dbus_err=0, captured request cleared; dbus_stall=0 while rst=1.
REQ-029 Reset in BUSY discards the pending store (array unchanged); array contents not cleared by reset.
REQ-030 First request accepted on the first clock edge after rst deasserts.

Verification
REQ-031 LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> stall 2 cycles each, rvalid on cycle 2, rdata 0xDEADBEEF, err 0.
REQ-032 Word 0x20=0x11223344; SB addr 0x22 data 0xAA -> word 0x11AA3344; SH addr 0x20 data 0xBEEF -> 0x11AABEEF.
REQ-033 SH addr 0x21 and SW addr 0x22 -> err=1 at completion, word unchanged on readback.
REQ-034 LW addr BASE_ADDR+4*DEPTH_WORDS -> err=1, rdata=0; LW BASE_ADDR-4 (wraps) -> err=1.
REQ-035 SW 0x30 data 0x55 with rst pulsed during BUSY -> outputs zero immediately, readback of 0x30 equals prior value.
REQ-036 LATENCY=1, four back-to-back LW requests -> pattern stall=1,rvalid=1 alternating, each completing in 2 cycles, no lost request.
